// File: rtl/alu_defs_pkg.sv
// ---------------------------------------------------------------------------
// alu_defs_pkg
//   Shared definitions for the ALU self-test slice: ALUControl op-codes,
//   self-test FSM state encoding, flag bit positions inside the packed
//   {V,N,Zero} flag/mask vectors, and the default vector count.
// ---------------------------------------------------------------------------
package alu_defs_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Bit positions inside the 3-bit flag and flag-mask vectors.
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    localparam int unsigned NUM_VEC_DEFAULT = 10;

    // first_fail value meaning "no vector has failed".
    localparam logic [3:0] NO_FAIL = 4'hF;

    function automatic logic [2:0] pack_flags(input logic v, input logic n, input logic z);
        logic [2:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_vector_rom.sv
// ---------------------------------------------------------------------------
// alu_vector_rom
//   Combinational table of ALU test vectors.
//   idx_i         : vector index
//   a_o, b_o      : operands
//   op_o          : ALUControl op-code
//   exp_result_o  : expected Result
//   exp_flags_o   : expected {V,N,Zero} (positions from alu_defs_pkg)
//   flag_mask_o   : which flags are compared; 0 means flags ignored
//   Indices beyond the table return an all-zero ADD 0+0 -> 0, flags ignored.
// ---------------------------------------------------------------------------
module alu_vector_rom
    import alu_defs_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       idx_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [2:0]       op_o,
    output logic [WIDTH-1:0] exp_result_o,
    output logic [2:0]       exp_flags_o,
    output logic [2:0]       flag_mask_o
);

    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] r32;
    alu_op_e     op;

    always_comb begin
        a32         = '0;
        b32         = '0;
        r32         = '0;
        op          = OP_ADD;
        exp_flags_o = '0;
        flag_mask_o = '0;
        case (idx_i)
            4'd0: begin
                a32 = 32'd124; b32 = 32'd73; op = OP_ADD; r32 = 32'd197;
                exp_flags_o = pack_flags(1'b0, 1'b0, 1'b0); flag_mask_o = '1;
            end
            4'd1: begin
                a32 = 32'd124; b32 = 32'd73; op = OP_SUB; r32 = 32'd51;
                exp_flags_o = pack_flags(1'b0, 1'b0, 1'b0); flag_mask_o = '1;
            end
            4'd2: begin
                a32 = 32'd20; b32 = 32'd120; op = OP_SUB; r32 = 32'hFFFF_FF9C;
                exp_flags_o = pack_flags(1'b0, 1'b1, 1'b0); flag_mask_o = '1;
            end
            4'd3: begin
                a32 = 32'd124; b32 = 32'd124; op = OP_SUB; r32 = 32'd0;
                exp_flags_o = pack_flags(1'b0, 1'b0, 1'b1); flag_mask_o = '1;
            end
            4'd4: begin
                a32 = 32'd124; b32 = 32'd124; op = OP_AND; r32 = 32'd124;
            end
            4'd5: begin
                a32 = 32'hF0F0_F0F0; b32 = 32'h0F0F_0F0F; op = OP_OR; r32 = 32'hFFFF_FFFF;
            end
            4'd6: begin
                a32 = 32'hFFFF_0000; b32 = 32'h0FF0_0FF0; op = OP_XOR; r32 = 32'hF00F_0FF0;
            end
            4'd7: begin
                a32 = 32'd1; b32 = 32'd31; op = OP_SLL; r32 = 32'h8000_0000;
            end
            4'd8: begin
                a32 = 32'h8000_0000; b32 = 32'd4; op = OP_SRL; r32 = 32'h0800_0000;
            end
            4'd9: begin
                a32 = 32'd20; b32 = 32'd120; op = OP_SLT; r32 = 32'd1;
            end
            default: ;
        endcase
        a_o          = WIDTH'(a32);
        b_o          = WIDTH'(b32);
        op_o         = op;
        exp_result_o = WIDTH'(r32);
    end

endmodule

// File: rtl/alu_selftest.sv
// ---------------------------------------------------------------------------
// alu_selftest
//   Sequential self-test engine for the combinational ALU. Applies each
//   table vector for one cycle (APPLY), samples the ALU in the next (CHECK),
//   then reports pass / fail_count / first_fail with a one-cycle done pulse.
//   clk, reset (async, active-high), start (honoured in IDLE only)
//   alu_a, alu_b, alu_ctrl : registered drive to the ALU inputs
//   alu_result, alu_v, alu_n, alu_zero : ALU outputs under test
//   busy, done, pass, fail_count, first_fail : status
// ---------------------------------------------------------------------------
module alu_selftest
    import alu_defs_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_VEC = NUM_VEC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       fail_count,
    output logic [3:0]       first_fail
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] exp_result_q, exp_result_d;
    logic [2:0]       exp_flags_q, exp_flags_d;
    logic [2:0]       flag_mask_q, flag_mask_d;
    logic             pass_q, pass_d;
    logic [4:0]       fail_count_q, fail_count_d;
    logic [3:0]       first_fail_q, first_fail_d;

    logic [3:0]       rom_idx;
    logic [WIDTH-1:0] rom_a, rom_b, rom_result;
    logic [2:0]       rom_op, rom_flags, rom_mask;
    logic             mismatch;

    // The ROM is addressed by the index of the vector about to be loaded,
    // so the operand registers and the expected values are captured
    // together on the edge that enters APPLY.
    assign rom_idx = (state_q == ST_CHECK) ? idx_q + 4'd1 : '0;

    alu_vector_rom #(
        .WIDTH(WIDTH)
    ) u_rom (
        .idx_i        (rom_idx),
        .a_o          (rom_a),
        .b_o          (rom_b),
        .op_o         (rom_op),
        .exp_result_o (rom_result),
        .exp_flags_o  (rom_flags),
        .flag_mask_o  (rom_mask)
    );

    assign mismatch = (alu_result != exp_result_q) ||
                      (((pack_flags(alu_v, alu_n, alu_zero) ^ exp_flags_q) & flag_mask_q) != '0);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        exp_result_d = exp_result_q;
        exp_flags_d  = exp_flags_q;
        flag_mask_d  = flag_mask_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_APPLY;
                    idx_d        = '0;
                    fail_count_d = '0;
                    first_fail_d = NO_FAIL;
                    pass_d       = 1'b0;
                    alu_a_d      = rom_a;
                    alu_b_d      = rom_b;
                    alu_ctrl_d   = rom_op;
                    exp_result_d = rom_result;
                    exp_flags_d  = rom_flags;
                    flag_mask_d  = rom_mask;
                end
            end
            ST_APPLY: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + 5'd1;
                    if (first_fail_q == NO_FAIL) begin
                        first_fail_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d    = ST_DONE;
                    alu_a_d    = '0;
                    alu_b_d    = '0;
                    alu_ctrl_d = '0;
                    // Result is visible alongside the done pulse.
                    pass_d     = (fail_count_d == '0);
                end else begin
                    state_d      = ST_APPLY;
                    idx_d        = idx_q + 4'd1;
                    alu_a_d      = rom_a;
                    alu_b_d      = rom_b;
                    alu_ctrl_d   = rom_op;
                    exp_result_d = rom_result;
                    exp_flags_d  = rom_flags;
                    flag_mask_d  = rom_mask;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            exp_result_q <= '0;
            exp_flags_q  <= '0;
            flag_mask_q  <= '0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= NO_FAIL;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            exp_result_q <= exp_result_d;
            exp_flags_q  <= exp_flags_d;
            flag_mask_q  <= flag_mask_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign busy       = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_alu_selftest.sv
// ---------------------------------------------------------------------------
// tb_alu_selftest
//   Drives alu_selftest against a behavioural ALU with injectable faults.
//   Expected run outcomes are predicted from the vector table and pushed to
//   a scoreboard queue at start; a monitor pops and compares on each done.
// ---------------------------------------------------------------------------
module tb_alu_selftest;

    localparam int NV = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic        alu_v, alu_n, alu_zero;
    logic        busy, done, pass;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail;

    always #5 clk = ~clk;

    alu_selftest #(
        .WIDTH   (32),
        .NUM_VEC (NV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_v      (alu_v),
        .alu_n      (alu_n),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count),
        .first_fail (first_fail)
    );

    // Vector table as written in the specification.
    logic [31:0] TA  [NV] = '{32'd124, 32'd124, 32'd20, 32'd124, 32'd124,
                              32'hF0F0F0F0, 32'hFFFF0000, 32'd1, 32'h80000000, 32'd20};
    logic [31:0] TB  [NV] = '{32'd73, 32'd73, 32'd120, 32'd124, 32'd124,
                              32'h0F0F0F0F, 32'h0FF00FF0, 32'd31, 32'd4, 32'd120};
    int          TOP [NV] = '{0, 1, 1, 1, 2, 3, 4, 5, 6, 7};
    logic [31:0] ER  [NV] = '{32'd197, 32'd51, 32'hFFFFFF9C, 32'd0, 32'd124,
                              32'hFFFFFFFF, 32'hF00F0FF0, 32'h80000000, 32'h08000000, 32'd1};
    int          EVNZ[NV] = '{0, 0, 2, 1, 0, 0, 0, 0, 0, 0};
    int          CHK [NV] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

    typedef struct packed {
        logic [31:0] r;
        logic        v;
        logic        n;
        logic        z;
    } alu_out_t;

    typedef struct {
        int fc;
        int ff;
        int ps;
        int t;
    } exp_t;

    // Fault modes: 0 none, 1 flip result bit fbit on vector fvec,
    // 2 Zero stuck-at-0, 3 V stuck-at-1, 4 N stuck-at-0.
    int fm = 0, fvec = 0, fbit = 0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_k = 0;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic alu_out_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        alu_out_t o;
        o = '0;
        case (op)
            3'd0: begin o.r = a + b; o.v = (a[31] == b[31]) && (o.r[31] != a[31]); end
            3'd1: begin o.r = a - b; o.v = (a[31] != b[31]) && (o.r[31] != a[31]); end
            3'd2: o.r = a & b;
            3'd3: o.r = a | b;
            3'd4: o.r = a ^ b;
            3'd5: o.r = a << b[4:0];
            3'd6: o.r = a >> b[4:0];
            default: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        o.n = o.r[31];
        o.z = (o.r == 32'd0);
        return o;
    endfunction

    function automatic alu_out_t faulty_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                            input int m, input int vi, input int bi);
        alu_out_t o;
        o = ref_alu(a, b, op);
        if (m == 1 && a == TA[vi] && b == TB[vi] && int'(op) == TOP[vi]) o.r[bi] = ~o.r[bi];
        if (m == 2) o.z = 1'b0;
        if (m == 3) o.v = 1'b1;
        if (m == 4) o.n = 1'b0;
        return o;
    endfunction

    alu_out_t alu_o;
    always_comb begin
        alu_o      = faulty_alu(alu_a, alu_b, alu_ctrl, fm, fvec, fbit);
        alu_result = alu_o.r;
        alu_v      = alu_o.v;
        alu_n      = alu_o.n;
        alu_zero   = alu_o.z;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic predict(output exp_t e);
        alu_out_t o;
        logic     bad;
        e.fc = 0;
        e.ff = 15;
        for (int i = 0; i < NV; i++) begin
            o   = faulty_alu(TA[i], TB[i], 3'(TOP[i]), fm, fvec, fbit);
            bad = (o.r != ER[i]) || (CHK[i] != 0 && int'({o.v, o.n, o.z}) != EVNZ[i]);
            if (bad) begin
                if (e.ff == 15) e.ff = i;
                e.fc++;
            end
        end
        e.ps = (e.fc == 0) ? 1 : 0;
        e.t  = 0;
    endtask

    // Monitor: checks applied vectors during APPLY and the run outcome at done.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_k = 0;
        end else begin
            if (busy) begin
                if (busy_k % 2 == 0 && busy_k / 2 < NV) begin
                    chk("apply_a", alu_a, TA[busy_k / 2]);
                    chk("apply_b", alu_b, TB[busy_k / 2]);
                    chk("apply_ctrl", {29'd0, alu_ctrl}, TOP[busy_k / 2]);
                end
                busy_k++;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_latency", cyc, e.t + 2 * NV + 1);
                    chk("busy_cycles", busy_k, 2 * NV);
                    chk("fail_count", {27'd0, fail_count}, e.fc);
                    chk("first_fail", {28'd0, first_fail}, e.ff);
                    chk("pass", {31'd0, pass}, e.ps);
                    chk("done_ctrl_zero", {29'd0, alu_ctrl}, 32'd0);
                end
                busy_k = 0;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_fail_count"}, {27'd0, fail_count}, 32'd0);
        chk({tag, "_first_fail"}, {28'd0, first_fail}, 32'hF);
        chk({tag, "_alu_ctrl"}, {29'd0, alu_ctrl}, 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
    endtask

    task automatic do_run(input int m, input int vi, input int bi, input bit pulse_mid, input bit pulse_done);
        exp_t e;
        bit   seen;
        fm = m; fvec = vi; fbit = bi;
        predict(e);
        @(negedge clk);
        start = 1'b1;
        e.t   = cyc;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("run_busy_t1", {31'd0, busy}, 32'd1);
        chk("run_clear_fc", {27'd0, fail_count}, 32'd0);
        chk("run_clear_ff", {28'd0, first_fail}, 32'hF);
        chk("run_clear_pass", {31'd0, pass}, 32'd0);
        if (pulse_mid) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        if (pulse_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("start_in_done_ignored_1", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("start_in_done_ignored_2", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic mid_reset_run();
        exp_t e;
        int   dones;
        fm = 0; fvec = 0; fbit = 0;
        predict(e);
        @(negedge clk);
        start = 1'b1;
        e.t   = cyc;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_vals("midreset");
        sbq.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midreset_no_done", dones, 32'd0);
        chk("midreset_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset");

        do_run(0, 0, 0, 1'b0, 1'b0);   // clean ALU
        do_run(1, 2, 0, 1'b0, 1'b0);   // Result bit0 flipped on SUB with A=20
        do_run(2, 0, 0, 1'b0, 1'b1);   // Zero stuck-at-0, start pulsed in DONE
        do_run(0, 0, 0, 1'b1, 1'b0);   // start re-pulsed mid-run, clears prior failure
        mid_reset_run();
        do_run(0, 0, 0, 1'b0, 1'b0);   // fresh run after abort
        do_run(3, 0, 0, 1'b0, 1'b0);   // V stuck-at-1
        do_run(4, 0, 0, 1'b0, 1'b0);   // N stuck-at-0

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run(int'($urandom_range(0, 4)), int'($urandom_range(0, NV - 1)),
                   int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
